// File: rtl/stream_buffer_pkg.sv
// Shared sizing helpers for the stream buffer family.
package stream_buffer_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry pointer still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_spill_buffer_wrap_counter.sv
// Modulo-MAX pointer: synchronous clear, enable increment, wraps MAX-1 -> 0.
module wrap_counter #(
  parameter int unsigned MAX   = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == WIDTH'(MAX - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_spill_buffer.sv
// DEPTH-entry fully registered valid/ready elastic buffer with flush, occupancy and almost-full.
module stream_spill_buffer
  import stream_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned AFULL_TH   = DEPTH - 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        almost_full_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  if (DEPTH < 2) begin : gen_depth_chk
    $error("stream_spill_buffer: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : gen_afull_chk
    $error("stream_spill_buffer: AFULL_TH must be in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  almost_full_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  clr, push, pop;

  assign clr = rst_i | flush_i;

  // Handshake outputs depend only on state and clr, keeping both directions cut.
  assign ready_o = (count_q != CW'(DEPTH)) & ~clr;
  assign valid_o = (count_q != '0) & ~clr;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  wrap_counter #(
    .MAX   (DEPTH),
    .WIDTH (PW)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .clr_i (clr),
    .en_i  (push),
    .cnt_o (wr_ptr)
  );

  wrap_counter #(
    .MAX   (DEPTH),
    .WIDTH (PW)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .clr_i (clr),
    .en_i  (pop),
    .cnt_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      almost_full_q <= (count_d >= CW'(AFULL_TH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign data_o        = mem_q[rd_ptr];
  assign count_o       = count_q;
  assign almost_full_o = almost_full_q;

  a_data_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> $stable(data_o));

  a_count_range : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_stream_spill_buffer.sv
// Directed and model-based checks of stream_spill_buffer at DEPTH 4, 3 and 2.
module tb_stream_spill_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DEPTH=4, AFULL_TH=3
  logic       f4, v4, r4, rdy4, vo4, af4;
  logic [7:0] di4, do4;
  logic [2:0] c4;
  // DEPTH=3
  logic       f3, v3, r3, rdy3, vo3, af3;
  logic [7:0] di3, do3;
  logic [1:0] c3;
  // DEPTH=2
  logic       f2, v2, r2, rdy2, vo2, af2;
  logic [7:0] di2, do2;
  logic [1:0] c2;

  stream_spill_buffer #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_TH(3)) u_d4 (
    .clk_i(clk), .rst_i(rst), .flush_i(f4), .valid_i(v4), .ready_o(rdy4), .data_i(di4),
    .valid_o(vo4), .ready_i(r4), .data_o(do4), .count_o(c4), .almost_full_o(af4)
  );

  stream_spill_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(f3), .valid_i(v3), .ready_o(rdy3), .data_i(di3),
    .valid_o(vo3), .ready_i(r3), .data_o(do3), .count_o(c3), .almost_full_o(af3)
  );

  stream_spill_buffer #(.DATA_WIDTH(8), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(f2), .valid_i(v2), .ready_o(rdy2), .data_i(di2),
    .valid_o(vo2), .ready_i(r2), .data_o(do2), .count_o(c2), .almost_full_o(af2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q3[$];
  logic [7:0] q2[$];
  int         sent;
  logic       exp_r, exp_v;

  initial begin
    rst = 1'b1;
    {f4, v4, r4, di4} = '0;
    {f3, v3, r3, di3} = '0;
    {f2, v2, r2, di2} = '0;
    tick();
    tick();
    check_eq("rst_ready", 32'(rdy4), 0);
    check_eq("rst_valid", 32'(vo4), 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(rdy4), 1);
    check_eq("post_rst_valid", 32'(vo4), 0);
    check_eq("post_rst_count", 32'(c4), 0);
    check_eq("post_rst_afull", 32'(af4), 0);

    // 1: streaming with ready_i held high
    r4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v4  = (i < 8);
      di4 = 8'(i + 1);
      #1;
      check_eq("t1_valid", 32'(vo4), (i >= 1 && i <= 8) ? 1 : 0);
      check_eq("t1_count", 32'(c4), (i >= 1 && i <= 8) ? 1 : 0);
      if (i >= 1 && i <= 8) check_eq("t1_data", 32'(do4), 32'(i));
      tick();
    end
    v4 = 1'b0;
    r4 = 1'b0;

    // 2: fill under backpressure, then drain
    for (int k = 0; k < 4; k++) begin
      v4  = 1'b1;
      di4 = 8'(8'hA0 + k);
      #1;
      check_eq("t2_ready", 32'(rdy4), 1);
      check_eq("t2_count", 32'(c4), 32'(k));
      check_eq("t2_afull", 32'(af4), (k >= 3) ? 1 : 0);
      check_eq("t2_valid", 32'(vo4), (k >= 1) ? 1 : 0);
      if (k >= 1) check_eq("t2_hold", 32'(do4), 32'hA0);
      tick();
    end
    di4 = 8'hEE;
    r4  = 1'b1;
    #1;
    check_eq("t2_full_ready", 32'(rdy4), 0);
    check_eq("t2_full_count", 32'(c4), 4);
    check_eq("t2_full_afull", 32'(af4), 1);
    check_eq("t2_full_data", 32'(do4), 32'hA0);
    tick();
    v4 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("t2_drain_ready", 32'(rdy4), 1);
      check_eq("t2_drain_valid", 32'(vo4), 1);
      check_eq("t2_drain_count", 32'(c4), 32'(4 - k));
      check_eq("t2_drain_data", 32'(do4), 32'(8'hA0 + k));
      tick();
    end
    #1;
    check_eq("t2_empty_count", 32'(c4), 0);
    check_eq("t2_empty_valid", 32'(vo4), 0);
    r4 = 1'b0;

    // 4: flush with three stored beats and a beat offered
    for (int k = 0; k < 3; k++) begin
      v4  = 1'b1;
      di4 = 8'(8'h11 * (k + 1));
      tick();
    end
    f4  = 1'b1;
    v4  = 1'b1;
    di4 = 8'h55;
    r4  = 1'b1;
    #1;
    check_eq("t4_flush_ready", 32'(rdy4), 0);
    check_eq("t4_flush_valid", 32'(vo4), 0);
    check_eq("t4_flush_count", 32'(c4), 3);
    check_eq("t4_flush_afull", 32'(af4), 1);
    tick();
    f4 = 1'b0;
    v4 = 1'b0;
    r4 = 1'b0;
    #1;
    check_eq("t4_after_count", 32'(c4), 0);
    check_eq("t4_after_valid", 32'(vo4), 0);
    check_eq("t4_after_ready", 32'(rdy4), 1);
    check_eq("t4_after_afull", 32'(af4), 0);
    v4  = 1'b1;
    di4 = 8'h66;
    tick();
    v4 = 1'b0;
    #1;
    check_eq("t4_new_valid", 32'(vo4), 1);
    check_eq("t4_new_data", 32'(do4), 32'h66);
    check_eq("t4_new_count", 32'(c4), 1);
    r4 = 1'b1;
    tick();
    r4 = 1'b0;
    #1;
    check_eq("t4_pop_count", 32'(c4), 0);

    // 5: reset while holding two beats
    v4  = 1'b1;
    di4 = 8'h77;
    tick();
    di4 = 8'h88;
    tick();
    v4  = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_ready", 32'(rdy4), 0);
    check_eq("t5_rst_valid", 32'(vo4), 0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("t5_count", 32'(c4), 0);
    check_eq("t5_ready", 32'(rdy4), 1);
    r4 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("t5_no_stale", 32'(vo4), 0);
      tick();
    end
    v4  = 1'b1;
    di4 = 8'h99;
    tick();
    v4 = 1'b0;
    #1;
    check_eq("t5_new_valid", 32'(vo4), 1);
    check_eq("t5_new_data", 32'(do4), 32'h99);
    check_eq("t5_new_count", 32'(c4), 1);
    tick();
    r4 = 1'b0;

    // 3: DEPTH=3 wrap with alternating ready_i, against a queue scoreboard
    sent = 0;
    for (int c = 0; c < 100 && (sent < 10 || q3.size() != 0); c++) begin
      r3  = (c % 2 == 0);
      v3  = (sent < 10);
      di3 = 8'(8'h30 + sent);
      #1;
      exp_r = (q3.size() != 3);
      exp_v = (q3.size() != 0);
      check_eq("t3_ready", 32'(rdy3), 32'(exp_r));
      check_eq("t3_valid", 32'(vo3), 32'(exp_v));
      check_eq("t3_count", 32'(c3), 32'(q3.size()));
      if (exp_v) check_eq("t3_data", 32'(do3), 32'(q3[0]));
      if (exp_v && r3) void'(q3.pop_front());
      if (v3 && exp_r) begin
        q3.push_back(di3);
        sent++;
      end
      tick();
    end
    v3 = 1'b0;
    r3 = 1'b0;
    check_eq("t3_sent", 32'(sent), 10);
    check_eq("t3_left", 32'(q3.size()), 0);

    // 6: DEPTH=2 random traffic against a 2-entry spill model
    for (int c = 0; c < 10000; c++) begin
      v2  = 1'($urandom_range(0, 1));
      r2  = 1'($urandom_range(0, 1));
      di2 = 8'($urandom);
      #1;
      exp_r = (q2.size() != 2);
      exp_v = (q2.size() != 0);
      check_eq("t6_ready", 32'(rdy2), 32'(exp_r));
      check_eq("t6_valid", 32'(vo2), 32'(exp_v));
      if (exp_v) check_eq("t6_data", 32'(do2), 32'(q2[0]));
      if (exp_v && r2) void'(q2.pop_front());
      if (v2 && exp_r) q2.push_back(di2);
      tick();
    end
    v2 = 1'b0;
    r2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
